// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants for the sprite renderer (colour width,
// transparent colour key, default sprite size, raster coordinate width).
package sprite_pkg;

    localparam int RGB_W     = 12;
    localparam int COORD_W   = 10;
    localparam int SPR_W_DEF = 16;
    localparam int SPR_H_DEF = 16;

    // ROM texels of this colour let the background show through.
    localparam logic [RGB_W-1:0] TRANSPARENT = 12'hF0F;

endpackage

// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if: sprite position write port from game logic.
// Build option SPRITE_MIRROR_EN adds a flip_x bit travelling with the position.
//
// Handshake: a position transfers on a rising clk edge where pos_valid and
// pos_ready are both 1. The master may hold pos_valid while pos_ready is 0,
// and must keep pos_x/pos_y (and flip_x) stable while it does so.
interface sprite_renderer_if;
    import sprite_pkg::*;

    logic               pos_valid;
    logic               pos_ready;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
`ifdef SPRITE_MIRROR_EN
    logic               flip_x;

    modport master (output pos_valid, output pos_x, output pos_y, output flip_x,
                    input pos_ready);
    modport slave  (input pos_valid, input pos_x, input pos_y, input flip_x,
                    output pos_ready);
`else
    modport master (output pos_valid, output pos_x, output pos_y,
                    input pos_ready);
    modport slave  (input pos_valid, input pos_x, input pos_y,
                    output pos_ready);
`endif

endinterface

// File: rtl/sprite_renderer_ptick_delay.sv
// ptick_delay: two-deep delay line advancing only on the pixel enable.
// Both taps are exposed so the caller can use the stage-1 copy as well.
module ptick_delay #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    // Shift one step per pixel enable; hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1 <= '0;
            q2 <= '0;
        end else if (en) begin
            q1 <= d;
            q2 <= q1;
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: overlays one sprite from a synchronous colour ROM onto a
// flat background, two-pixel-enable pipeline, syncs delayed to match rgb.
// Position updates are double-buffered and only take effect at the vsync
// rising edge. Build option SPRITE_MIRROR_EN enables horizontal mirroring.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int                SPR_W    = SPR_W_DEF,
    parameter int                SPR_H    = SPR_H_DEF,
    parameter logic [RGB_W-1:0]  BG_COLOR = 12'h49F
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            p_tick,
    input  logic                            video_on,
    input  logic                            hsync,
    input  logic                            vsync,
    input  logic [COORD_W-1:0]              pixel_x,
    input  logic [COORD_W-1:0]              pixel_y,
    sprite_renderer_if.slave                pos,
    output logic [$clog2(SPR_W*SPR_H)-1:0]  rom_addr,
    input  logic [RGB_W-1:0]                rom_data,
    output logic [RGB_W-1:0]                rgb,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            frame_tick
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);
    localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(SPR_W);
    localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(SPR_H);

    logic [COORD_W-1:0] active_x, active_y;
    logic [COORD_W-1:0] shadow_x, shadow_y;
    logic               pending;
    logic               vs_q, vs_q2;
    logic               vs_edge, xfer;
`ifdef SPRITE_MIRROR_EN
    logic               active_flip, shadow_flip;
`endif

    assign vs_edge       = vs_q & ~vs_q2;
    assign xfer          = pos.pos_valid & pos.pos_ready;
    assign pos.pos_ready = ~pending;

    // Vsync edge detector in the clk domain; frame_tick is its registered pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q       <= 1'b0;
            vs_q2      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= vsync;
            vs_q2      <= vs_q;
            frame_tick <= vs_edge;
        end
    end

    // Shadow/active position: writes park in the shadow, vsync edge promotes;
    // a write landing on the edge with an empty shadow goes straight to active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_x    <= '0;
            active_y    <= '0;
            shadow_x    <= '0;
            shadow_y    <= '0;
            pending     <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            active_flip <= 1'b0;
            shadow_flip <= 1'b0;
`endif
        end else if (vs_edge) begin
            if (pending) begin
                active_x    <= shadow_x;
                active_y    <= shadow_y;
`ifdef SPRITE_MIRROR_EN
                active_flip <= shadow_flip;
`endif
                pending     <= 1'b0;
            end else if (xfer) begin
                active_x    <= pos.pos_x;
                active_y    <= pos.pos_y;
`ifdef SPRITE_MIRROR_EN
                active_flip <= pos.flip_x;
`endif
            end
        end else if (xfer) begin
            shadow_x    <= pos.pos_x;
            shadow_y    <= pos.pos_y;
`ifdef SPRITE_MIRROR_EN
            shadow_flip <= pos.flip_x;
`endif
            pending     <= 1'b1;
        end
    end

    // Hit test at 11 bits so a sprite near the right/bottom edge clips instead
    // of wrapping; texel column/row are the low bits of the raster offset.
    logic [COORD_W:0]   px_w, py_w, ax_w, ay_w;
    logic               hit;
    logic [COL_W-1:0]   col_raw, col;
    logic [ROW_W-1:0]   row;

    always_comb begin
        px_w    = {1'b0, pixel_x};
        py_w    = {1'b0, pixel_y};
        ax_w    = {1'b0, active_x};
        ay_w    = {1'b0, active_y};
        hit     = (px_w >= ax_w) && (px_w < ax_w + W_EXT) &&
                  (py_w >= ay_w) && (py_w < ay_w + H_EXT);
        col_raw = COL_W'(pixel_x - active_x);
        row     = ROW_W'(pixel_y - active_y);
        col     = col_raw;
`ifdef SPRITE_MIRROR_EN
        if (active_flip) begin
            col = COL_W'(SPR_W - 1) - col_raw;
        end
`endif
    end

    // Stage 1: ROM address and hit flag, advancing on the pixel enable.
    logic hit_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q    <= 1'b0;
            rom_addr <= '0;
        end else if (p_tick) begin
            hit_q    <= hit;
            rom_addr <= hit ? {row, col} : '0;
        end
    end

    // Syncs and video_on travel through the same two pixel-enable stages.
    logic [2:0] tap1, tap2;
    logic       unused_taps;

    ptick_delay #(.WIDTH(3)) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (p_tick),
        .d       ({vsync, hsync, video_on}),
        .q1      (tap1),
        .q2      (tap2)
    );

    assign hsync_out   = tap2[1];
    assign vsync_out   = tap2[2];
    assign unused_taps = ^{tap1[2:1], tap2[0]};

    // Stage 2: colour select; the ROM word for stage 1's address is ready by now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb <= '0;
        end else if (p_tick) begin
            if (!tap1[0]) begin
                rgb <= '0;
            end else if (hit_q && (rom_data != TRANSPARENT)) begin
                rgb <= rom_data;
            end else begin
                rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-generation stage directly downstream of the VGA timing generator. Consumes the raster coordinates, `video_on`, `p_tick` and sync pulses, overlays one 16x16 sprite from a synchronous colour ROM onto a flat background, and emits 12-bit RGB with hsync/vsync re-aligned to the pipeline. Sprite position is written by game logic through a valid/ready port and takes effect only at the start of vertical retrace, so a frame is never torn.

## Interface
- `SPR_W`, 16: sprite width in pixels (power of two).
- `SPR_H`, 16: sprite height in pixels (power of two).
- `BG_COLOR`, 12'h49F: background RGB inside the visible area.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low.
- `p_tick`  input  1  pixel enable, at most one pulse every 2 `clk` cycles.
- `video_on`  input  1  visible-area flag.
- `hsync`, `vsync`  input  1 each  sync pulses, active-high during retrace.
- `pixel_x`, `pixel_y`  input  10 each  current raster coordinate.
- `pos_valid`  input  1  new sprite position offered.
- `pos_ready`  output  1  shadow register free.
- `pos_x`, `pos_y`  input  10 each  sprite top-left corner.
- `rom_addr`  output  log2(SPR_W*SPR_H)  sprite ROM address (row-major).
- `rom_data`  input  12  ROM output, valid one `clk` after `rom_addr`.
- `rgb`  output  12  pixel colour.
- `hsync_out`, `vsync_out`  output  1 each  syncs delayed to match `rgb`.
- `frame_tick`  output  1  one-`clk` pulse at vsync rising edge.

## Operation
- Reset values: `rgb`=0, `hsync_out`=0, `vsync_out`=0, `rom_addr`=0, `frame_tick`=0, `pos_ready`=1; active position (0,0); shadow empty.
- Position handshake: transfer when `pos_valid && pos_ready`; loads shadow, sets `pending`; `pos_ready` = !`pending`. Holding `pos_valid` with `pos_ready`=0 is legal; data must stay stable.
- Vsync edge (registered `vsync` 0->1, clk domain): `frame_tick`=1 for one clk; if `pending`, active <= shadow, `pending` cleared.
- Simultaneous transfer and vsync edge with `pending`=0: new value goes straight to active, `pending` stays 0.
- Stage 1 (on `p_tick`): hit = `pixel_x` >= ax && `pixel_x` < ax+SPR_W && `pixel_y` >= ay && `pixel_y` < ay+SPR_H, compared at 11 bits (no wrap; sprites at x>624 clip). `rom_addr` <= (`pixel_y`-ay)*SPR_W + (`pixel_x`-ax), truncated to address width; 0 on miss. Hit, `video_on`, `hsync`, `vsync` registered.
- Stage 2 (on next `p_tick`): `rgb` <= !von ? 0 : (hit && `rom_data` != TRANSPARENT) ? `rom_data` : BG_COLOR. Syncs shifted to `hsync_out`/`vsync_out`.
- Between `p_tick`s all pipeline registers hold.
- Reset mid-frame: all state clears immediately; outputs resume valid after two `p_tick`s.

## Timing
- Pixel latency: exactly 2 `p_tick`s from inputs to `rgb`; `hsync_out`/`vsync_out`/internal `video_on` share that latency.
- ROM: address registered on a `p_tick` clk, sampled at the following `p_tick` (>=2 clk later), so a 1-clk ROM suffices.
- `pos_ready` rises the clk after the vsync edge that drains the shadow.
- `frame_tick` asserts the clk after `vsync` is first sampled high.

## Configuration
- `SPRITE_MIRROR_EN` defined: extra input `flip_x` (1 bit) captured with `pos_x/pos_y` into shadow/active; when active flip is 1, column = SPR_W-1-(`pixel_x`-ax).
- Undefined: no `flip_x` port; column = `pixel_x`-ax.

## Structure
- Package `sprite_pkg`: `RGB_W`=12, `TRANSPARENT`=12'hF0F, default SPR_W/SPR_H, coordinate width 10.
- One sub-module `ptick_delay`: parameterised-width, p_tick-enabled 2-deep delay line for syncs/`video_on`.

## Test plan
- Reset released, no position written, raster at (5,5), `video_on`=1, ROM returns 12'h0F0 -> after 2 `p_tick`s `rgb`=12'h0F0, `rom_addr`=5*16+5=85.
- Active (100,200), pixel (99,200) and (116,200) -> `rgb`=BG_COLOR; pixel (115,215) -> `rom_addr`=255.
- ROM returns 12'hF0F inside sprite -> `rgb`=BG_COLOR; `video_on`=0 -> `rgb`=0.
- Write (300,50) mid-frame -> `pos_ready`=0, second write stalls, old position drawn until vsync edge; `frame_tick` pulses, `pos_ready`=1 next clk, next frame uses (300,50).
- Write coinciding with vsync edge, shadow empty -> active updated same edge, `pos_ready` stays 1.
- `SPRITE_MIRROR_EN`, flip_x=1, active (0,0), pixel (0,0) -> `rom_addr`=15; assert `reset_n`=0 mid-line -> `rgb`=0, syncs 0, `pos_ready`=1 asynchronously.
